// File: rtl/scaler_vout_rchn_if.sv
// AXI4-Stream pixel channel between the line-buffer read side and the video output.
interface scaler_vout_rchn_if #(
  parameter int unsigned DW = 8
) ();
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic          tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/scaler_vout_rchn.sv
// Read channel of the scaler output ping-pong line buffer: counts filled buffers,
// drains them PING/PONG in turn through a credit-checked read pipeline into a skid
// FIFO, and streams each line out as AXI4-Stream with tlast.
module scaler_vout_rchn #(
  parameter int unsigned BRAM_ADDR_BITWIDTH = 11,
  parameter int unsigned BRAM_DATA_BITWIDTH = 8,
  parameter int unsigned BRAM_RD_LATENCY    = 2,
  parameter int unsigned FIFO_DEPTH         = 8
) (
  input  logic                          core_clk,
  input  logic                          core_rst,
  input  logic                          core_start,
  input  logic [BRAM_ADDR_BITWIDTH:0]   cfg_hsize,
  input  logic                          wdone,
  output logic                          wfull,
  output logic [1:0]                    enb,
  output logic [BRAM_ADDR_BITWIDTH-1:0] addrb,
  input  logic [BRAM_DATA_BITWIDTH-1:0] doutb_ping,
  input  logic [BRAM_DATA_BITWIDTH-1:0] doutb_pong,
  scaler_vout_rchn_if.master            m_axis
);
  localparam int unsigned AW  = BRAM_ADDR_BITWIDTH;
  localparam int unsigned DW  = BRAM_DATA_BITWIDTH;
  localparam int unsigned LAT = BRAM_RD_LATENCY;
  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam logic [PW+1:0] DEPTH_C = (PW+2)'(FIFO_DEPTH);
  localparam logic [AW:0]   ONE_C   = {{AW{1'b0}}, 1'b1};

  typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_READ, ST_DRAIN, ST_REL} state_t;

  state_t          state_q, state_d;
  logic [1:0]      fill_q, fill_d;
  logic            wfull_q;
  logic            rsw_q, rsw_d;
  logic [AW:0]     len_q, len_d, addr_q, addr_d, last_addr;
  logic            issue, rel;

  logic [LAT-1:0]  pvld_q, psel_q, plast_q;
  logic [PW:0]     in_flight;

  logic [DW:0]     mem_q [FIFO_DEPTH];
  logic [PW:0]     wr_q, rd_q, used;
  logic [PW+1:0]   occ;
  logic            empty, push, pop;
  logic [DW:0]     push_word, head;

  assign last_addr = len_q - ONE_C;
  assign used      = wr_q - rd_q;
  assign empty     = (used == '0);
  assign occ       = {1'b0, used} + {1'b0, in_flight};
  assign push      = pvld_q[LAT-1];
  assign pop       = !empty && m_axis.tready;
  assign push_word = {plast_q[LAT-1], psel_q[LAT-1] ? doutb_pong : doutb_ping};
  assign head      = mem_q[rd_q[PW-1:0]];

  assign wfull         = wfull_q;
  assign enb           = issue ? (rsw_q ? 2'b10 : 2'b01) : 2'b00;
  assign addrb         = issue ? addr_q[AW-1:0] : '0;
  assign m_axis.tvalid = !empty;
  assign m_axis.tdata  = empty ? '0 : head[DW-1:0];
  assign m_axis.tlast  = !empty && head[DW];

  // Reads still travelling through the BRAM latency pipeline.
  always_comb begin
    in_flight = '0;
    for (int unsigned i = 0; i < LAT; i++) in_flight = in_flight + (PW+1)'(pvld_q[i]);
  end

  // Line-drain sequencer: next state, read issue and buffer release.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    addr_d  = addr_q;
    rsw_d   = rsw_q;
    issue   = 1'b0;
    rel     = 1'b0;
    case (state_q)
      ST_IDLE:  if (core_start) state_d = ST_WAIT;
      ST_WAIT: begin
        if (fill_q != 2'd0) begin
          len_d   = cfg_hsize;
          addr_d  = '0;
          state_d = (cfg_hsize == '0) ? ST_REL : ST_READ;
        end
      end
      ST_READ: begin
        // Credit covers FIFO occupancy plus reads not yet landed, so no push can overflow.
        if (occ < DEPTH_C) begin
          issue  = 1'b1;
          addr_d = addr_q + ONE_C;
          if (addr_q == last_addr) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: if (in_flight == '0) state_d = ST_REL;
      ST_REL: begin
        rel     = 1'b1;
        rsw_d   = !rsw_q;
        state_d = ST_WAIT;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Filled-buffer count: writer increments, release decrements, saturating at 2.
  always_comb begin
    fill_d = fill_q;
    case ({wdone, rel})
      2'b10:   fill_d = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
      2'b01:   fill_d = fill_q - 2'd1;
      default: fill_d = fill_q;
    endcase
  end

  // Control state, buffer count, availability flag and line counters.
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state_q <= ST_IDLE;
      fill_q  <= 2'd0;
      wfull_q <= 1'b1;
      rsw_q   <= 1'b0;
      len_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      wfull_q <= (fill_q != 2'd2);
      rsw_q   <= rsw_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
    end
  end

  // BRAM latency pipeline carrying valid, buffer select and end-of-line.
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      pvld_q  <= '0;
      psel_q  <= '0;
      plast_q <= '0;
    end else begin
      pvld_q[0]  <= issue;
      psel_q[0]  <= rsw_q;
      plast_q[0] <= (addr_q == last_addr);
      for (int unsigned i = 1; i < LAT; i++) begin
        pvld_q[i]  <= pvld_q[i-1];
        psel_q[i]  <= psel_q[i-1];
        plast_q[i] <= plast_q[i-1];
      end
    end
  end

  // Skid FIFO pointers; reset discards any queued pixels.
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + (PW+1)'(1);
      if (pop)  rd_q <= rd_q + (PW+1)'(1);
    end
  end

  // Skid FIFO storage.
  always_ff @(posedge core_clk) begin
    if (push) mem_q[wr_q[PW-1:0]] <= push_word;
  end
endmodule

// File: tb/tb_scaler_vout_rchn.sv
// Directed bench for scaler_vout_rchn with a 2-cycle BRAM model and a stream monitor.
module tb_scaler_vout_rchn;
  localparam int LAT = 2;

  logic        core_clk, core_rst, core_start, wdone, wfull;
  logic [11:0] cfg_hsize;
  logic [1:0]  enb;
  logic [10:0] addrb;
  logic [7:0]  doutb_ping, doutb_pong;
  logic [7:0]  ping_mem [2048];
  logic [7:0]  pong_mem [2048];
  logic [7:0]  ping_r0, ping_r1, pong_r0, pong_r1;

  scaler_vout_rchn_if #(.DW(8)) m_if ();

  scaler_vout_rchn #(
    .BRAM_ADDR_BITWIDTH(11), .BRAM_DATA_BITWIDTH(8),
    .BRAM_RD_LATENCY(LAT),   .FIFO_DEPTH(8)
  ) dut (
    .core_clk(core_clk), .core_rst(core_rst), .core_start(core_start),
    .cfg_hsize(cfg_hsize), .wdone(wdone), .wfull(wfull), .enb(enb), .addrb(addrb),
    .doutb_ping(doutb_ping), .doutb_pong(doutb_pong), .m_axis(m_if)
  );

  int n_checks = 0, n_errors = 0;
  int cyc = 0, rdy_mode = 0;
  int first_enb_cyc, first_vld_cyc, first_pong_cyc, last_rd_cyc, watch_addr;
  int n_rd, n_pop, max_out, stall_viol, n_wfull_low;
  logic [1:0]  first_enb_val;
  logic [10:0] first_addr;
  logic        pong_wfull, pong_prev_wfull, prev_wfull;
  logic        stall_q = 1'b0, stall_last;
  logic [7:0]  stall_data;
  logic [8:0]  q [$];
  int target, w;

  function automatic logic [7:0] exp_pix(input bit sel, input int idx);
    return sel ? 8'((idx * 5 + 128) & 255) : 8'((idx * 3 + 1) & 255);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;
  always @(posedge core_clk) cyc <= cyc + 1;

  initial for (int i = 0; i < 2048; i++) begin
    ping_mem[i] = exp_pix(1'b0, i);
    pong_mem[i] = exp_pix(1'b1, i);
  end

  // BRAM model: data appears LAT cycles after the enabled read.
  always @(posedge core_clk) begin
    if (enb[0]) ping_r0 <= ping_mem[addrb];
    if (enb[1]) pong_r0 <= pong_mem[addrb];
    ping_r1 <= ping_r0;
    pong_r1 <= pong_r0;
  end
  assign doutb_ping = ping_r1;
  assign doutb_pong = pong_r1;

  // Downstream ready: always, or one cycle in three.
  always begin
    @(posedge core_clk); #1;
    m_if.tready = (rdy_mode == 0) || (cyc % 3 == 0);
  end

  // Monitor sampled on the falling edge.
  always @(negedge core_clk) begin
    if (enb != 2'b00) begin
      n_rd++;
      if (first_enb_cyc < 0) begin
        first_enb_cyc = cyc; first_enb_val = enb; first_addr = addrb;
      end
      if (enb == 2'b10 && first_pong_cyc < 0) begin
        first_pong_cyc = cyc; pong_wfull = wfull; pong_prev_wfull = prev_wfull;
      end
      if (int'(addrb) == watch_addr && last_rd_cyc < 0) last_rd_cyc = cyc;
    end
    if (m_if.tvalid === 1'b1 && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (stall_q && (m_if.tvalid !== 1'b1 || m_if.tdata !== stall_data || m_if.tlast !== stall_last))
      stall_viol++;
    stall_q    = (m_if.tvalid === 1'b1) && (m_if.tready !== 1'b1);
    stall_data = m_if.tdata;
    stall_last = m_if.tlast;
    if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
      q.push_back({m_if.tlast, m_if.tdata});
      n_pop++;
    end
    if (n_rd - n_pop > max_out) max_out = n_rd - n_pop;
    if (wfull === 1'b0) n_wfull_low++;
    prev_wfull = wfull;
  end

  task automatic step();
    @(posedge core_clk); #1;
  endtask

  task automatic clear_stats();
    first_enb_cyc = -1; first_vld_cyc = -1; first_pong_cyc = -1; last_rd_cyc = -1;
    watch_addr = -1; n_rd = 0; n_pop = 0; max_out = 0; stall_viol = 0; n_wfull_low = 0;
    q.delete();
  endtask

  task automatic do_reset();
    core_rst = 1'b1; step(); step(); core_rst = 1'b0;
    clear_stats();
  endtask

  task automatic start();
    core_start = 1'b1; step(); core_start = 1'b0;
  endtask

  task automatic pulse_wdone();
    wdone = 1'b1; step(); wdone = 1'b0;
  endtask

  task automatic check_line(input string tag, input bit sel, input int len, input int budget);
    int waited = 0, bad = 0, badlast = 0, got;
    logic [8:0] b;
    while (q.size() < len && waited < budget) begin step(); waited++; end
    got = (q.size() < len) ? q.size() : len;
    check({tag, "_beats"}, got, len);
    for (int k = 0; k < len && q.size() > 0; k++) begin
      b = q.pop_front();
      if (b[7:0] !== exp_pix(sel, k)) bad++;
      if (b[8] !== (k == len - 1)) badlast++;
    end
    check({tag, "_data"}, bad, 0);
    check({tag, "_last"}, badlast, 0);
  endtask

  initial begin
    core_rst = 1'b1; core_start = 1'b0; wdone = 1'b0; cfg_hsize = 12'd16;
    clear_stats();
    repeat (3) step();
    check("rst_wfull", wfull, 1);
    check("rst_enb", enb, 0);
    check("rst_addrb", addrb, 0);
    check("rst_tvalid", m_if.tvalid, 0);
    check("rst_tlast", m_if.tlast, 0);
    check("rst_tdata", m_if.tdata, 0);
    core_rst = 1'b0;
    clear_stats();

    // 1: single 16-pixel line from PING, then the next buffer comes from PONG
    start();
    pulse_wdone();
    check_line("t1_ping", 1'b0, 16, 200);
    check("t1_latency", first_vld_cyc - first_enb_cyc, LAT + 1);
    repeat (30) step();
    check("t1_wfull", wfull, 1);
    check("t1_extra", q.size(), 0);
    pulse_wdone();
    check_line("t1_pong", 1'b1, 16, 200);
    repeat (30) step();
    check("t1_extra2", q.size(), 0);

    // 2: two buffers filled, a third fill attempt is ignored
    do_reset();
    start();
    wdone = 1'b1; step(); step(); step(); wdone = 1'b0;
    check("t2_wfull_low", wfull, 0);
    check_line("t2_ping", 1'b0, 16, 300);
    check_line("t2_pong", 1'b1, 16, 300);
    check("t2_wfull_before_rise", pong_prev_wfull, 0);
    check("t2_wfull_rise", pong_wfull, 1);
    repeat (60) step();
    check("t2_no_third", q.size(), 0);
    check("t2_wfull_end", wfull, 1);

    // 3: 32 pixels under 1-in-3 backpressure
    do_reset();
    cfg_hsize = 12'd32;
    start();
    rdy_mode = 1;
    pulse_wdone();
    check_line("t3", 1'b0, 32, 600);
    check("t3_max_outstanding", max_out, 8);
    check("t3_stall_stable", stall_viol, 0);
    rdy_mode = 0;
    repeat (5) step();

    // 4: a refill lands in the release cycle of the only full buffer
    do_reset();
    cfg_hsize = 12'd4;
    start();
    watch_addr = 3;
    pulse_wdone();
    w = 0;
    while (last_rd_cyc < 0 && w < 100) begin step(); w++; end
    check("t4_last_read_seen", last_rd_cyc >= 0, 1);
    target = last_rd_cyc + LAT + 2;
    while (cyc < target) step();
    pulse_wdone();
    check_line("t4_ping", 1'b0, 4, 100);
    check_line("t4_pong", 1'b1, 4, 100);
    check("t4_immediate", first_pong_cyc, target + 2);
    repeat (40) step();
    check("t4_extra", q.size(), 0);
    check("t4_wfull_never_low", n_wfull_low, 0);

    // 5: reset mid-line, then a fresh line from PING address 0
    do_reset();
    cfg_hsize = 12'd16;
    start();
    pulse_wdone();
    w = 0;
    while (n_pop < 5 && w < 100) begin step(); w++; end
    check("t5_five_beats", n_pop >= 5, 1);
    core_rst = 1'b1; step(); core_rst = 1'b0;
    check("t5_tvalid", m_if.tvalid, 0);
    check("t5_enb", enb, 0);
    check("t5_wfull", wfull, 1);
    clear_stats();
    repeat (5) step();
    start();
    pulse_wdone();
    check_line("t5_line", 1'b0, 16, 200);
    check("t5_first_enb", first_enb_val, 2'b01);
    check("t5_first_addr", first_addr, 0);

    // 6: full 2048-pixel line, then a single-pixel line
    do_reset();
    cfg_hsize = 12'd2048;
    start();
    pulse_wdone();
    check_line("t6_full", 1'b0, 2048, 4000);
    repeat (20) step();
    cfg_hsize = 12'd1;
    pulse_wdone();
    check_line("t6_one", 1'b1, 1, 100);
    repeat (30) step();
    check("t6_extra", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
